// File: rtl/mem_pkg.sv
// Shared widths, burst depth and FSM state encoding for the run-time table loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_LEN    = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collisions.
// Latency: read data 1 cycle after re; writes land on the same edge.
// Backpressure: none, both ports accept every cycle.
module ram_sdp #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset so tables survive a block reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/memory_ram_writer.sv
// Burst loader storing a valid/ready word stream at sequential wrapping addresses; optional XOR checksum (CHECKSUM_EN).
// Latency: each accepted word written on its accept edge; done 1 cycle after last accept; read port 1 cycle.
// Backpressure: wr_ready high only while a burst is in progress; wr_valid low simply stalls.
module memory_ram_writer
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    input  logic              en,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] waddr;
    logic              accept;
    logic              start_ok;

    assign len_clamped = (len > MAX_CNT) ? MAX_CNT : len;
    assign accept      = wr_valid && (state_q == WRITE);
    // Address arithmetic is ADDR_W wide so bursts wrap past the top of memory.
    assign waddr       = base_q + count_q[ADDR_W-1:0];
    assign count       = count_q;

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = (len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                if (accept && ((count_q + ONE) == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q  <= base_addr;
                len_q   <= len_clamped;
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + ONE;
            end
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ wr_data;
        end
    end
`endif

    ram_sdp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (waddr),
        .wdata (wr_data),
        .re    (en),
        .raddr (address),
        .rdata (out)
    );
endmodule

// File: tb/tb_memory_ram_writer.sv
// Bench for memory_ram_writer: directed and randomized bursts against an array model of memory/checksum.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: wr_valid patterns are back-to-back, alternating or random.
module tb_memory_ram_writer;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  len = '0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        en = 1'b0;
    logic [3:0]  address = '0;
    logic [15:0] out;
`ifdef CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int          nchecks = 0;
    int          nerrors = 0;
    logic [15:0] ref_mem [16];
    bit          ref_valid [16];
    logic [15:0] wq [$];
    logic [15:0] last_csum;

    always #5 clk = ~clk;

    memory_ram_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .en        (en),
        .address   (address),
        .out       (out)
`ifdef CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_words(input int n, input int kind, input logic [15:0] seed);
        wq.delete();
        for (int i = 0; i < n; i++) begin
            if (kind == 0) wq.push_back(seed + 16'(i));
            else           wq.push_back(16'($urandom));
        end
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid plus stray starts.
    task automatic do_burst(input int b, input int l, input int mode, input int stop_at);
        int          n;
        int          idx;
        int          cyc;
        int          a;
        logic        v;
        logic [15:0] old;
        bit          had;
        logic [15:0] csum;
        n = (l > MAX_LEN) ? MAX_LEN : l;
        start = 1'b1;
        base_addr = b[3:0];
        len = l[4:0];
        tick();
        start = 1'b0;
        check("start_count", count, 0);
        check("start_busy", busy, (n > 0) ? 1 : 0);
        idx = 0;
        cyc = 0;
        csum = '0;
        while (idx < n && idx != stop_at && cyc < 400) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            if (mode == 2) begin
                start = 1'($urandom_range(0, 1));
                base_addr = 4'($urandom);
                len = 5'($urandom);
            end
            a = (b + idx) % 16;
            wr_valid = v;
            wr_data = wq[idx];
            en = 1'b1;
            address = a[3:0];
            old = ref_mem[a];
            had = ref_valid[a];
            check("wr_ready_mid", wr_ready, 1);
            check("busy_mid", busy, 1);
            tick();
            if (had) check("read_first", out, old);
            if (v) begin
                ref_mem[a] = wq[idx];
                ref_valid[a] = 1'b1;
                csum ^= wq[idx];
                idx++;
            end
            cyc++;
        end
        wr_valid = 1'b0;
        start = 1'b0;
        en = 1'b0;
        if (stop_at >= 0 && idx == stop_at) return;
        if (idx < n) begin
            nchecks++;
            nerrors++;
            $error("FAIL burst_timeout: observed %0d accepts expected %0d", idx, n);
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", wr_ready, 0);
        check("done_count", count, n);
`ifdef CHECKSUM_EN
        check("checksum", checksum, csum);
`endif
        last_csum = csum;
        tick();
        check("done_once", done, 0);
        check("idle_ready", wr_ready, 0);
        check("count_hold", count, n);
`ifdef CHECKSUM_EN
        check("checksum_hold", checksum, last_csum);
`endif
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            en = 1'b1;
            address = 4'(a);
            tick();
            if (ref_valid[a]) check($sformatf("read_%0d", a), out, ref_mem[a]);
        end
        en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            ref_valid[i] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_out", out, 0);
`ifdef CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst = 1'b0;
        tick();

        fill_words(16, 0, 16'h1000);
        do_burst(0, 16, 0, -1);
        read_all();

        // Wrap past address 15; address 2 must still hold 0x1002.
        wq.delete();
        wq.push_back(16'hAAAA); wq.push_back(16'hBBBB);
        wq.push_back(16'hCCCC); wq.push_back(16'hDDDD);
        do_burst(14, 4, 0, -1);
        read_all();
        en = 1'b1;
        address = 4'd2;
        tick();
        check("wrap_addr2", out, 16'h1002);
        address = 4'd0;
        en = 1'b0;
        tick();
        check("en_hold", out, 16'h1002);

        fill_words(3, 1, '0);
        do_burst($urandom_range(0, 15), 3, 1, -1);

        do_burst(7, 0, 0, -1);

        fill_words(16, 1, '0);
        do_burst($urandom_range(0, 15), 20, 2, -1);
        read_all();

        wq.delete();
        wq.push_back(16'h00FF); wq.push_back(16'hFF00); wq.push_back(16'h1234);
        do_burst(9, 3, 0, -1);
        check("csum_model", last_csum, 16'hEDCB);

        fill_words(5, 1, '0);
        do_burst(5, 5, 0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", wr_ready, 0);
        check("abort_count", count, 0);
        tick();
        check("abort_no_done", done, 0);
        read_all();

        for (int t = 0; t < 6; t++) begin
            int l;
            l = $urandom_range(1, 16);
            fill_words(l, 1, '0);
            do_burst($urandom_range(0, 15), l, $urandom_range(0, 2), -1);
        end
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
